// File: rtl/ksa_pkg.sv
// Shared constants and types for the 32-bit Kogge-Stone adder pipeline.
package ksa_pkg;
  localparam int KSA_WIDTH  = 32;
  localparam int KSA_SPAN8  = 8;
  localparam int KSA_SPAN16 = 16;

  typedef logic [KSA_WIDTH-1:0] gp_vec_t;
endpackage

// File: rtl/gp_window.sv
// Prefix cell merging a high group (g_hi,p_hi) with the adjacent lower group (g_lo,p_lo).
module gp_window (
  input  logic g_hi_i,
  input  logic p_hi_i,
  input  logic g_lo_i,
  input  logic p_lo_i,
  output logic g_o,
  output logic p_o
);
  assign g_o = g_hi_i | (p_hi_i & g_lo_i);
  assign p_o = p_hi_i & p_lo_i;
endmodule

// File: rtl/ksa_span_stage.sv
// One combinational Kogge-Stone prefix level: bit i merges with bit i-SPAN; low SPAN bits pass through.
module ksa_span_stage
  import ksa_pkg::*;
#(
  parameter int SPAN = KSA_SPAN8
) (
  input  gp_vec_t g_i,
  input  gp_vec_t p_i,
  output gp_vec_t g_o,
  output gp_vec_t p_o
);
  for (genvar gi = 0; gi < KSA_WIDTH; gi++) begin : g_bit
    if (gi < SPAN) begin : g_pass
      assign g_o[gi] = g_i[gi];
      assign p_o[gi] = p_i[gi];
    end else begin : g_merge
      gp_window u_cell (
        .g_hi_i (g_i[gi]),
        .p_hi_i (p_i[gi]),
        .g_lo_i (g_i[gi-SPAN]),
        .p_lo_i (p_i[gi-SPAN]),
        .g_o    (g_o[gi]),
        .p_o    (p_o[gi])
      );
    end
  end
endmodule

// File: rtl/ksa_stage5_sum_pipe.sv
// Span-8/span-16 prefix levels plus sum/carry-out, as a two-register valid/ready pipeline.
// Optional signed-overflow output enabled by defining KSA_OVERFLOW_FLAG_EN.
module ksa_stage5_sum_pipe
  import ksa_pkg::*;
#(
  parameter int WIDTH = KSA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] g_in,
  input  logic [WIDTH-1:0] p_in,
  input  logic [WIDTH-1:0] hs_in,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef KSA_OVERFLOW_FLAG_EN
  ,output logic            ovf
`endif
);
  if (WIDTH != KSA_WIDTH) begin : g_width_check
    $error("ksa_stage5_sum_pipe supports only WIDTH=32");
  end

  logic    a_valid_q;
  gp_vec_t g8_q, p8_q, hs_q;
  logic    cin_q;
  logic    out_valid_q;
  gp_vec_t sum_q;
  logic    cout_q;

  gp_vec_t g8_d, p8_d;
  gp_vec_t gfull, pfull;
  logic [KSA_WIDTH:0] carry;
  gp_vec_t sum_d;
  logic    b_load, a_load;

  assign b_load = !out_valid_q || out_ready;
  assign a_load = !a_valid_q || b_load;

  ksa_span_stage #(.SPAN(KSA_SPAN8)) u_span8 (
    .g_i (g_in),
    .p_i (p_in),
    .g_o (g8_d),
    .p_o (p8_d)
  );

  ksa_span_stage #(.SPAN(KSA_SPAN16)) u_span16 (
    .g_i (g8_q),
    .p_i (p8_q),
    .g_o (gfull),
    .p_o (pfull)
  );

  // After span-16 every bit holds the full prefix [i:0], so carries need only cin.
  assign carry = {gfull | (pfull & {KSA_WIDTH{cin_q}}), cin_q};
  assign sum_d = hs_q ^ carry[KSA_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid_q <= 1'b0;
      g8_q      <= '0;
      p8_q      <= '0;
      hs_q      <= '0;
      cin_q     <= 1'b0;
    end else if (a_load) begin
      a_valid_q <= in_valid;
      g8_q      <= g8_d;
      p8_q      <= p8_d;
      hs_q      <= hs_in;
      cin_q     <= cin;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
    end else if (b_load) begin
      out_valid_q <= a_valid_q;
      sum_q       <= sum_d;
      cout_q      <= carry[KSA_WIDTH];
    end
  end

`ifdef KSA_OVERFLOW_FLAG_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (b_load) begin
      ovf_q <= carry[KSA_WIDTH-1] ^ carry[KSA_WIDTH];
    end
  end

  assign ovf = ovf_q;
`endif

  assign in_ready  = a_load;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
endmodule

// File: tb/tb_ksa_stage5_sum_pipe.sv
// Randomized and directed bench for ksa_stage5_sum_pipe against an arithmetic a+b+cin model.
module tb_ksa_stage5_sum_pipe;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] g_in = '0, p_in = '0, hs_in = '0;
  logic        cin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] sum;
  logic        cout;
`ifdef KSA_OVERFLOW_FLAG_EN
  logic        ovf;
`endif

  int errors = 0;
  int checks = 0;
  int n_out  = 0;

  // {ovf, cout, sum} of each accepted beat, in acceptance order
  logic [33:0] exp_q[$];
  logic        hold_pend = 1'b0;
  logic [33:0] hold_val;

  always #5 clk = ~clk;

  ksa_stage5_sum_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .g_in      (g_in),
    .p_in      (p_in),
    .hs_in     (hs_in),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef KSA_OVERFLOW_FLAG_EN
    ,.ovf      (ovf)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Window generate/propagate for bits [i:max(0,i-7)] computed by adding the operand slices.
  function automatic logic [63:0] gp_stage4(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] g, p;
    for (int i = 0; i < 32; i++) begin
      int lo = (i >= 7) ? i - 7 : 0;
      int w  = i - lo + 1;
      longint unsigned mask = (64'd1 << w) - 1;
      longint unsigned aw = (longint'(a) >> lo) & mask;
      longint unsigned bw = (longint'(b) >> lo) & mask;
      longint unsigned xw = (longint'(a ^ b) >> lo) & mask;
      g[i] = (((aw + bw) >> w) & 1) != 0;
      p[i] = (xw == mask);
    end
    return {g, p};
  endfunction

  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b, input logic c);
    logic [32:0] full = {1'b0, a} + {1'b0, b} + {32'd0, c};
    logic        v = (a[31] == b[31]) && (full[31] != a[31]);
    return {v, full};
  endfunction

  function automatic logic [33:0] observed();
`ifdef KSA_OVERFLOW_FLAG_EN
    return {ovf, cout, sum};
`else
    return {1'b0, cout, sum};
`endif
  endfunction

  // Runs one clock: drive at negedge, sample just after, score both interfaces, then pass the posedge.
  task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] b, input logic c,
                       input logic ordy, output logic acc, output logic ov);
    logic [63:0] gp;
    logic [33:0] got, exp;
    @(negedge clk);
    gp = gp_stage4(a, b);
    in_valid = v; g_in = gp[63:32]; p_in = gp[31:0]; hs_in = a ^ b; cin = c;
    out_ready = ordy;
    #1;
    acc = v && in_ready;
    ov  = out_valid;
    got = observed();
`ifndef KSA_OVERFLOW_FLAG_EN
    got[33] = 1'b0;
`endif
    if (hold_pend) begin
      check("stall_valid_held", {63'd0, out_valid}, 64'd1);
      check("stall_data_held", {30'd0, got}, {30'd0, hold_val});
    end
    hold_pend = out_valid && !ordy;
    hold_val  = got;
    if (out_valid && ordy) begin
      if (exp_q.size() == 0) begin
        check("spurious_output", 64'd1, 64'd0);
      end else begin
        exp = exp_q.pop_front();
`ifndef KSA_OVERFLOW_FLAG_EN
        exp[33] = 1'b0;
`endif
        check("result", {30'd0, got}, {30'd0, exp});
        n_out++;
      end
    end
    if (acc) exp_q.push_back(model(a, b, c));
    @(posedge clk);
  endtask

  logic        acc, ov;
  logic [31:0] ra, rb;
  int          k, fires, sent, guard;

  initial begin
    // reset state
    #1;
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_sum_cout", {31'd0, cout, sum}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1; #1;
    check("reset_in_ready", {63'd0, in_ready}, 64'd1);

    // single beat latency: output valid after the second edge, not the first
    cycle(1, 32'h0000FFFF, 32'h00000001, 0, 1, acc, ov);
    check("single_accept", {63'd0, acc}, 64'd1);
    cycle(0, 0, 0, 0, 1, acc, ov);
    check("latency_not_early", {63'd0, ov}, 64'd0);
    cycle(0, 0, 0, 0, 1, acc, ov);
    check("latency_valid", {63'd0, ov}, 64'd1);
    check("single_sum", {31'd0, cout, sum}, {31'd0, 1'b0, 32'h00010000});
    cycle(0, 0, 0, 0, 1, acc, ov);
    check("single_drained", {63'd0, ov}, 64'd0);

    // full carry chain and signed overflow
    cycle(1, 32'hFFFFFFFF, 32'h0, 1, 1, acc, ov);
    cycle(1, 32'h7FFFFFFF, 32'h1, 0, 1, acc, ov);
    cycle(0, 0, 0, 0, 1, acc, ov);
    check("wrap_sum", {31'd0, cout, sum}, {31'd0, 1'b1, 32'h0});
`ifdef KSA_OVERFLOW_FLAG_EN
    check("wrap_ovf", {63'd0, ovf}, 64'd0);
`endif
    cycle(0, 0, 0, 0, 1, acc, ov);
    check("ovf_sum", {31'd0, cout, sum}, {31'd0, 1'b0, 32'h80000000});
`ifdef KSA_OVERFLOW_FLAG_EN
    check("ovf_flag", {63'd0, ovf}, 64'd1);
`endif
    cycle(0, 0, 0, 0, 1, acc, ov);

    // backpressure: only two beats fit, then in-order drain one per cycle
    k = 0;
    for (int n = 0; n < 6; n++) begin
      cycle(k < 4, 32'h100 * (k + 1), 32'h11 * (k + 3), k[0], 0, acc, ov);
      if (acc) k++;
    end
    check("bp_accepts", k, 2);
    check("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
    fires = 0;
    for (int n = 0; n < 4; n++) begin
      cycle(k < 4, 32'h100 * (k + 1), 32'h11 * (k + 3), k[0], 1, acc, ov);
      if (acc) k++;
      if (ov) fires++;
    end
    check("bp_one_per_cycle", fires, 4);
    cycle(0, 0, 0, 0, 1, acc, ov);
    check("bp_queue_empty", exp_q.size(), 0);

    // mid-operation reset with both stages full
    cycle(1, 32'h1234, 32'h5678, 0, 0, acc, ov);
    cycle(1, 32'h9ABC, 32'hDEF0, 1, 0, acc, ov);
    @(negedge clk);
    rst_n = 1'b0; #1;
    check("rst_out_valid_async", {63'd0, out_valid}, 64'd0);
    exp_q.delete();
    hold_pend = 1'b0;
    @(negedge clk); rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1; #1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    for (int n = 0; n < 3; n++) begin
      cycle(0, 0, 0, 0, 1, acc, ov);
      check("rst_no_stale", {63'd0, ov}, 64'd0);
    end

    // random back-to-back traffic with random backpressure
    sent = 0;
    guard = 0;
    while ((sent < 10000 || exp_q.size() != 0) && guard < 40000) begin
      ra = $urandom();
      rb = $urandom();
      if ($urandom_range(0, 7) == 0) ra = 32'hFFFFFFFF;
      cycle((sent < 10000) && ($urandom_range(0, 3) != 0), ra, rb, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) != 0), acc, ov);
      if (acc) sent++;
      guard++;
    end
    check("random_timeout", {63'd0, guard >= 40000}, 64'd0);
    check("random_all_out", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
